// File: rtl/sync_fifo_burst_reader_pkg.sv
// Shared types and parameter legality check for the sync_fifo burst reader.
// Imported by sync_fifo_burst_reader and sync_fifo_burst_reader_oreg.
package sync_fifo_burst_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // A burst needs at least two beats so that AE_LEVEL = BURST_LEN-1 is meaningful.
    function automatic bit params_legal(input int width, input int burst_len,
                                        input int timeout, input int cnt_w);
        return (width >= 1) && (burst_len >= 2) && (timeout >= 1) && (cnt_w >= 1);
    endfunction

endpackage

// File: rtl/sync_fifo_burst_reader_oreg.sv
// Single-entry output register for the burst reader stream side.
// Holds m_valid/m_data/m_last and reports when a new beat may be loaded.
module sync_fifo_burst_reader_oreg
    import sync_fifo_burst_reader_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_last,
    input  logic             m_ready,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic             slot_free,
    output logic             accept
);

    // The slot is free when empty or when its beat leaves this cycle.
    assign slot_free = !m_valid || m_ready;
    assign accept    = m_valid && m_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
        end else if (load) begin
            m_valid <= 1'b1;
            m_data  <= load_data;
            m_last  <= load_last;
        end else if (accept) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/sync_fifo_burst_reader.sv
// Read engine draining a show-ahead sync_fifo into BURST_LEN-beat stream bursts, flushing leftovers on timeout.
// Optional statistics counters (burst_cnt/flush_cnt) are built when SYNC_FIFO_BURST_READER_STATS_EN is defined.
module sync_fifo_burst_reader
    import sync_fifo_burst_reader_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 16,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] fifo_dout,
    input  logic             fifo_empty,
    input  logic             fifo_a_empty,
    output logic             fifo_pop,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic             busy
`ifdef SYNC_FIFO_BURST_READER_STATS_EN
    ,
    output logic [CNT_W-1:0] burst_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    localparam int BEAT_W = $clog2(BURST_LEN) + 1;
    localparam int TMR_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [BEAT_W-1:0] BURST_BEATS = BEAT_W'(BURST_LEN);
    localparam logic [BEAT_W-1:0] FLUSH_BEATS = BEAT_W'(1);
    localparam logic [TMR_W-1:0]  TMR_LAST    = TMR_W'(TIMEOUT - 1);

    if (!params_legal(WIDTH, BURST_LEN, TIMEOUT, CNT_W)) begin : g_param_check
        $error("sync_fifo_burst_reader: illegal parameter combination");
    end

    state_t            state;
    state_t            state_nxt;
    logic [BEAT_W-1:0] beat_cnt;
    logic [BEAT_W-1:0] beat_target;
    logic [TMR_W-1:0]  idle_tmr;
    logic              active;
    logic              beats_left;
    logic              load;
    logic              load_last;
    logic              slot_free;
    logic              accept;
    logic              pkt_done;

    assign active      = (state == BURST) || (state == FLUSH);
    assign beat_target = (state == BURST) ? BURST_BEATS : FLUSH_BEATS;
    assign beats_left  = beat_cnt < beat_target;
    assign load        = active && !fifo_empty && beats_left && slot_free;
    assign load_last   = (beat_cnt + BEAT_W'(1)) == beat_target;
    assign fifo_pop    = load && !rst;
    // m_valid is only ever high for beats of the current packet, so m_last is never stale here.
    assign pkt_done    = active && accept && m_last;
    assign busy        = active || m_valid;

    sync_fifo_burst_reader_oreg #(
        .WIDTH (WIDTH)
    ) u_oreg (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (fifo_dout),
        .load_last (load_last),
        .m_ready   (m_ready),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_last    (m_last),
        .slot_free (slot_free),
        .accept    (accept)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A full burst always wins over a pending timeout flush.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!fifo_a_empty) begin
                    state_nxt = BURST;
                end else if (!fifo_empty && (idle_tmr == TMR_LAST)) begin
                    state_nxt = FLUSH;
                end
            end
            BURST, FLUSH: begin
                if (pkt_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (pkt_done) begin
            beat_cnt <= '0;
        end else if (load) begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_tmr <= '0;
        end else if ((state != IDLE) || (state_nxt != IDLE) || fifo_empty) begin
            idle_tmr <= '0;
        end else begin
            idle_tmr <= idle_tmr + TMR_W'(1);
        end
    end

`ifdef SYNC_FIFO_BURST_READER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (pkt_done && (state == BURST) && (burst_cnt != '1)) begin
                burst_cnt <= burst_cnt + CNT_W'(1);
            end
            if (pkt_done && (state == FLUSH) && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_burst_reader.sv
// Self-checking bench for sync_fifo_burst_reader: queue-based FIFO and packet-level reference model.
// Define SYNC_FIFO_BURST_READER_STATS_EN to also check burst_cnt/flush_cnt.
module tb_sync_fifo_burst_reader;

    localparam int WIDTH     = 32;
    localparam int BURST_LEN = 4;
    localparam int TIMEOUT   = 16;
    localparam int CNT_W     = 16;
    localparam int FIFO_CAP  = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] fifo_dout;
    logic             fifo_empty;
    logic             fifo_a_empty;
    logic             fifo_pop;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;
    logic             busy;
`ifdef SYNC_FIFO_BURST_READER_STATS_EN
    logic [CNT_W-1:0] burst_cnt;
    logic [CNT_W-1:0] flush_cnt;
`endif

    sync_fifo_burst_reader #(
        .WIDTH     (WIDTH),
        .BURST_LEN (BURST_LEN),
        .TIMEOUT   (TIMEOUT),
        .CNT_W     (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_dout    (fifo_dout),
        .fifo_empty   (fifo_empty),
        .fifo_a_empty (fifo_a_empty),
        .fifo_pop     (fifo_pop),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .busy         (busy)
`ifdef SYNC_FIFO_BURST_READER_STATS_EN
        ,
        .burst_cnt    (burst_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             l;
        int               c;
    } beat_t;

    int               pass_cnt = 0;
    int               check_cnt = 0;
    int               cyc = 0;
    logic [WIDTH-1:0] fifo_q[$];
    bit               pop_now = 1'b0;
    beat_t            acc_q[$];
    int               pop_cyc_q[$];

    // Reference model: the packet in progress and the one-beat output slot
    bit               mdl_active = 1'b0;
    bit               mdl_is_burst = 1'b0;
    int               mdl_left = 0;
    int               mdl_idle = 0;
    bit               slot_v = 1'b0;
    logic [WIDTH-1:0] slot_d = '0;
    bit               slot_l = 1'b0;
    int               mdl_bursts = 0;
    int               mdl_flushes = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        check_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic void driveFifo();
        fifo_empty   = (fifo_q.size() == 0);
        fifo_a_empty = (fifo_q.size() < BURST_LEN);
        fifo_dout    = fifo_empty ? '0 : fifo_q[0];
    endfunction

    function automatic void pushWord(input logic [WIDTH-1:0] w);
        fifo_q.push_back(w);
        driveFifo();
    endfunction

    // The FIFO pops the head word at the edge where fifo_pop was seen high
    always @(posedge clk) begin
        #1;
        if (pop_now && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
        end
        pop_now = 1'b0;
        driveFifo();
    end

    // Compare on the falling edge, then advance the model by one clock
    always @(negedge clk) begin
        bit exp_pop;
        bit acc;
        int cnt;
        cyc++;
        cnt = fifo_q.size();
        if (rst) begin
            checkOutput("rst_fifo_pop", 64'(fifo_pop), 64'd0);
            checkOutput("rst_m_valid", 64'(m_valid), 64'd0);
            checkOutput("rst_m_data", 64'(m_data), 64'd0);
            checkOutput("rst_m_last", 64'(m_last), 64'd0);
            checkOutput("rst_busy", 64'(busy), 64'd0);
`ifdef SYNC_FIFO_BURST_READER_STATS_EN
            checkOutput("rst_burst_cnt", 64'(burst_cnt), 64'd0);
            checkOutput("rst_flush_cnt", 64'(flush_cnt), 64'd0);
            mdl_bursts  = 0;
            mdl_flushes = 0;
`endif
            mdl_active = 1'b0;
            mdl_left   = 0;
            mdl_idle   = 0;
            slot_v     = 1'b0;
            pop_now    = 1'b0;
        end else begin
            exp_pop = mdl_active && (mdl_left > 0) && (cnt > 0) && (!slot_v || m_ready);
            checkOutput("fifo_pop", 64'(fifo_pop), 64'(exp_pop));
            checkOutput("m_valid", 64'(m_valid), 64'(slot_v));
            if (slot_v) begin
                checkOutput("m_data", 64'(m_data), 64'(slot_d));
                checkOutput("m_last", 64'(m_last), 64'(slot_l));
            end
            checkOutput("busy", 64'(busy), 64'(mdl_active || slot_v));
`ifdef SYNC_FIFO_BURST_READER_STATS_EN
            checkOutput("burst_cnt", 64'(burst_cnt), 64'(mdl_bursts));
            checkOutput("flush_cnt", 64'(flush_cnt), 64'(mdl_flushes));
`endif
            pop_now = fifo_pop;
            if (fifo_pop) pop_cyc_q.push_back(cyc);
            if (m_valid && m_ready) acc_q.push_back('{m_data, m_last, cyc});

            acc = slot_v && m_ready;
            if (mdl_active) begin
                if (acc) begin
                    if (slot_l) begin
                        if (mdl_is_burst) mdl_bursts++;
                        else mdl_flushes++;
                        mdl_active = 1'b0;
                        mdl_idle   = 0;
                    end
                    slot_v = 1'b0;
                end
                if (exp_pop) begin
                    slot_v = 1'b1;
                    slot_d = fifo_q[0];
                    slot_l = (mdl_left == 1);
                    mdl_left--;
                end
            end else if (cnt >= BURST_LEN) begin
                mdl_active   = 1'b1;
                mdl_is_burst = 1'b1;
                mdl_left     = BURST_LEN;
                mdl_idle     = 0;
            end else if (cnt > 0 && mdl_idle == TIMEOUT - 1) begin
                mdl_active   = 1'b1;
                mdl_is_burst = 1'b0;
                mdl_left     = 1;
                mdl_idle     = 0;
            end else if (cnt > 0) begin
                mdl_idle++;
            end else begin
                mdl_idle = 0;
            end
        end
    end

    task automatic applyStimulus(input logic rdy);
        @(posedge clk);
        #2;
        m_ready = rdy;
    endtask

    task automatic waitIdle(input int bound, input string name);
        int n = 0;
        while (!(fifo_q.size() == 0 && !busy && !mdl_active && !slot_v) && n < bound) begin
            applyStimulus(1'b1);
            n++;
        end
        checkOutput(name, 64'(n < bound), 64'd1);
    endtask

    task automatic checkBeat(input string name, input int idx, input logic [WIDTH-1:0] d,
                             input logic l, input int c);
        if (idx < acc_q.size()) begin
            checkOutput({name, "_data"}, 64'(acc_q[idx].d), 64'(d));
            checkOutput({name, "_last"}, 64'(acc_q[idx].l), 64'(l));
            if (c >= 0) checkOutput({name, "_cycle"}, 64'(acc_q[idx].c), 64'(c));
        end else begin
            checkOutput({name, "_present"}, 64'(acc_q.size()), 64'(idx + 1));
        end
    endtask

    initial begin
        int c0;
        int base;
        int pbase;
        int n;
        rst     = 1'b1;
        m_ready = 1'b0;
        driveFifo();
        repeat (3) applyStimulus(1'b0);
        rst = 1'b0;
        applyStimulus(1'b1);

        // Scenario 1: one full burst, back-to-back
        c0 = cyc;
        base = acc_q.size();
        pbase = pop_cyc_q.size();
        for (int i = 0; i < 4; i++) pushWord(32'hA000_0000 + i);
        waitIdle(100, "s1_idle");
        checkOutput("s1_pop_count", 64'(pop_cyc_q.size() - pbase), 64'd4);
        if (pop_cyc_q.size() > pbase) checkOutput("s1_first_pop_cycle", 64'(pop_cyc_q[pbase]), 64'(c0 + 2));
        for (int i = 0; i < 4; i++) checkBeat("s1_beat", base + i, 32'hA000_0000 + i, (i == 3), c0 + 3 + i);

        // Scenario 3: two leftovers flushed as single-beat packets after the idle timeout
        c0 = cyc;
        base = acc_q.size();
        pbase = pop_cyc_q.size();
        pushWord(32'hB000_0000);
        pushWord(32'hB000_0001);
        waitIdle(200, "s3_idle");
        checkOutput("s3_pop_count", 64'(pop_cyc_q.size() - pbase), 64'd2);
        if (pop_cyc_q.size() > pbase + 1) begin
            checkOutput("s3_pop0_cycle", 64'(pop_cyc_q[pbase]), 64'(c0 + 17));
            checkOutput("s3_pop1_cycle", 64'(pop_cyc_q[pbase + 1]), 64'(c0 + 35));
        end
        checkBeat("s3_beat0", base, 32'hB000_0000, 1'b1, c0 + 18);
        checkBeat("s3_beat1", base + 1, 32'hB000_0001, 1'b1, c0 + 36);
`ifdef SYNC_FIFO_BURST_READER_STATS_EN
        checkOutput("stats_burst_cnt", 64'(burst_cnt), 64'd1);
        checkOutput("stats_flush_cnt", 64'(flush_cnt), 64'd2);
`endif

        // Scenario 2: alternating ready, beats must hold while stalled
        base = acc_q.size();
        pbase = pop_cyc_q.size();
        for (int i = 0; i < 4; i++) pushWord(32'hC000_0000 + i);
        for (int i = 0; i < 12; i++) applyStimulus((i % 2) == 0);
        waitIdle(100, "s2_idle");
        checkOutput("s2_pop_count", 64'(pop_cyc_q.size() - pbase), 64'd4);
        for (int i = 0; i < 4; i++) checkBeat("s2_beat", base + i, 32'hC000_0000 + i, (i == 3), -1);

        // Scenario 4: nine words -> two bursts and one flush
        base = acc_q.size();
        pbase = pop_cyc_q.size();
        for (int i = 0; i < 9; i++) pushWord(32'hD000_0000 + i);
        waitIdle(200, "s4_idle");
        checkOutput("s4_pop_count", 64'(pop_cyc_q.size() - pbase), 64'd9);
        for (int i = 0; i < 9; i++)
            checkBeat("s4_beat", base + i, 32'hD000_0000 + i, (i == 3 || i == 7 || i == 8), -1);
        checkOutput("s4_busy", 64'(busy), 64'd0);
        checkOutput("s4_fifo_empty", 64'(fifo_empty), 64'd1);

        // Scenario 5: reset in the middle of a burst
        base = acc_q.size();
        for (int i = 0; i < 4; i++) pushWord(32'hE000_0000 + i);
        n = 0;
        while (acc_q.size() < base + 2 && n < 50) begin
            applyStimulus(1'b1);
            n++;
        end
        checkOutput("s5_two_beats", 64'(n < 50), 64'd1);
        rst = 1'b1;
        #1;
        checkOutput("s5_async_m_valid", 64'(m_valid), 64'd0);
        checkOutput("s5_async_fifo_pop", 64'(fifo_pop), 64'd0);
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        rst = 1'b0;
        checkOutput("s5_fifo_left", 64'(fifo_q.size()), 64'd1);
        if (fifo_q.size() > 0) checkOutput("s5_fifo_head", 64'(fifo_q[0]), 64'h0000_0000_E000_0003);
        base = acc_q.size();
        for (int i = 0; i < 4; i++) pushWord(32'hF000_0000 + i);
        waitIdle(200, "s5_idle");
        checkBeat("s5_resume0", base, 32'hE000_0003, 1'b0, -1);
        checkBeat("s5_resume3", base + 3, 32'hF000_0002, 1'b1, -1);
        checkBeat("s5_flush", base + 4, 32'hF000_0003, 1'b1, -1);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(3) != 0));
            if (fifo_q.size() < FIFO_CAP && $urandom_range(2) == 0) pushWord($urandom);
        end
        waitIdle(300, "rand_drain");

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
